// File: rtl/apb4_slave_mem_responder.sv
// APB4 completer backed by an internal word memory, for use as a stand-in peripheral.
// Adds byte-lane writes, programmable wait states, error responses, protocol checks and a transfer counter.
module apb4_slave_mem_responder #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned NUM_SEL    = 32,
    parameter int unsigned SEL_INDEX  = 0,
    parameter int unsigned DEPTH      = 256,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = '0
) (
    input  logic                      PCLK,
    input  logic                      PRESETn,
    input  logic [ADDR_WIDTH-1:0]     PADDR,
    input  logic [NUM_SEL-1:0]        PSEL,
    input  logic                      PENABLE,
    input  logic                      PWRITE,
    input  logic [DATA_WIDTH-1:0]     PWDATA,
    input  logic [DATA_WIDTH/8-1:0]   PSTRB,
    output logic [DATA_WIDTH-1:0]     PRDATA,
    output logic                      PREADY,
    output logic                      PSLVERR,
    input  logic [3:0]                cfg_wait,
    input  logic                      cfg_err_inject,
    output logic                      prot_err,
    output logic [15:0]               xfer_count
);

    localparam int unsigned BYTES = DATA_WIDTH / 8;
    localparam int unsigned LSB   = $clog2(BYTES);
    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ADDR_WIDTH'(BYTES - 1);
    localparam logic [ADDR_WIDTH-1:0] DEPTH_A    = ADDR_WIDTH'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WAIT  = 2'd1,
        S_READY = 2'd2
    } state_t;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    state_t                r_state;
    logic [3:0]            r_cnt;
    logic [IDX_W-1:0]      r_idx;
    logic                  r_err;
    logic                  r_write;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [BYTES-1:0]      r_strb;
    logic [DATA_WIDTH-1:0] r_prdata;
    logic                  r_pready;
    logic                  r_pslverr;
    logic                  r_prot_err;
    logic [15:0]           r_xfer_count;

    logic                  w_sel;
    logic                  w_setup;
    logic                  w_access;
    logic [ADDR_WIDTH-1:0] w_off;
    logic [ADDR_WIDTH-1:0] w_idx_full;
    logic [IDX_W-1:0]      w_idx;
    logic                  w_misalign;
    logic                  w_oow;
    logic                  w_err;
    logic                  w_mem_we;
    logic                  w_unused;

    // Address decode of the live bus; only consumed at the setup edge.
    assign w_sel      = PSEL[SEL_INDEX];
    assign w_setup    = w_sel & ~PENABLE;
    assign w_access   = w_sel & PENABLE;
    assign w_off      = PADDR - BASE_ADDR;
    assign w_idx_full = w_off >> LSB;
    assign w_idx      = w_idx_full[IDX_W-1:0];
    assign w_misalign = |(PADDR & ALIGN_MASK);
    assign w_oow      = (PADDR < BASE_ADDR) || (w_idx_full >= DEPTH_A);
    assign w_err      = cfg_err_inject | w_misalign | w_oow;
    assign w_unused   = ^PSEL;

    // Memory commits only at a clean completion of an error-free write.
    assign w_mem_we = (r_state == S_READY) & w_access & r_write & ~r_err;

    always_ff @(posedge PCLK) begin
        if (w_mem_we) begin
            for (int unsigned b = 0; b < BYTES; b++) begin
                if (r_strb[b]) begin
                    mem[r_idx][b*8 +: 8] <= r_wdata[b*8 +: 8];
                end
            end
        end
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            r_state      <= S_IDLE;
            r_cnt        <= 4'd0;
            r_idx        <= '0;
            r_err        <= 1'b0;
            r_write      <= 1'b0;
            r_wdata      <= '0;
            r_strb       <= '0;
            r_prdata     <= '0;
            r_pready     <= 1'b0;
            r_pslverr    <= 1'b0;
            r_prot_err   <= 1'b0;
            r_xfer_count <= 16'd0;
        end else begin
            r_prot_err <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_setup) begin
                        r_idx   <= w_idx;
                        r_err   <= w_err;
                        r_write <= PWRITE;
                        r_wdata <= PWDATA;
                        r_strb  <= PSTRB;
                        if (cfg_wait == 4'd0) begin
                            r_state   <= S_READY;
                            r_pready  <= 1'b1;
                            r_pslverr <= w_err;
                            r_prdata  <= (!PWRITE && !w_err) ? mem[w_idx] : '0;
                        end else begin
                            r_state <= S_WAIT;
                            r_cnt   <= cfg_wait;
                        end
                    end else if (w_access) begin
                        // Access phase with no preceding setup.
                        r_prot_err <= 1'b1;
                    end
                end
                S_WAIT: begin
                    if (!w_access) begin
                        r_state    <= S_IDLE;
                        r_cnt      <= 4'd0;
                        r_prot_err <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                        if (r_cnt == 4'd1) begin
                            r_state   <= S_READY;
                            r_pready  <= 1'b1;
                            r_pslverr <= r_err;
                            r_prdata  <= (!r_write && !r_err) ? mem[r_idx] : '0;
                        end
                    end
                end
                S_READY: begin
                    if (w_access) begin
                        r_xfer_count <= r_xfer_count + 16'd1;
                    end else begin
                        r_prot_err <= 1'b1;
                    end
                    r_state   <= S_IDLE;
                    r_cnt     <= 4'd0;
                    r_pready  <= 1'b0;
                    r_pslverr <= 1'b0;
                    r_prdata  <= '0;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign PRDATA     = r_prdata;
    assign PREADY     = r_pready;
    assign PSLVERR    = r_pslverr;
    assign prot_err   = r_prot_err;
    assign xfer_count = r_xfer_count;

endmodule

// File: tb/tb_apb4_slave_mem_responder.sv
// Directed bench for apb4_slave_mem_responder: hand-computed expectations checked with immediate assertions.
module tb_apb4_slave_mem_responder;

    logic        PCLK = 1'b0;
    logic        PRESETn;
    logic [31:0] PADDR;
    logic [31:0] PSEL;
    logic        PENABLE;
    logic        PWRITE;
    logic [31:0] PWDATA;
    logic [3:0]  PSTRB;
    logic [31:0] PRDATA;
    logic        PREADY;
    logic        PSLVERR;
    logic [3:0]  cfg_wait;
    logic        cfg_err_inject;
    logic        prot_err;
    logic [15:0] xfer_count;

    int n_vec = 0;
    int n_err = 0;

    logic [31:0] rd;
    logic        se;
    int          wt;

    apb4_slave_mem_responder #(
        .ADDR_WIDTH(32), .DATA_WIDTH(32), .NUM_SEL(32), .SEL_INDEX(0),
        .DEPTH(256), .BASE_ADDR(32'h0000_1000)
    ) dut (
        .PCLK(PCLK), .PRESETn(PRESETn), .PADDR(PADDR), .PSEL(PSEL),
        .PENABLE(PENABLE), .PWRITE(PWRITE), .PWDATA(PWDATA), .PSTRB(PSTRB),
        .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
        .cfg_wait(cfg_wait), .cfg_err_inject(cfg_err_inject),
        .prot_err(prot_err), .xfer_count(xfer_count)
    );

    always #5 PCLK = ~PCLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    // Full transfer starting #1 after an edge; config is changed right after setup to show it is latched.
    task automatic xfer(input logic wr, input logic [31:0] addr, input logic [31:0] data,
                        input logic [3:0] strb, input logic [3:0] wcfg, input logic inj,
                        output logic [31:0] rdata, output logic slverr, output int waits);
        int n;
        PSEL = 32'h1; PENABLE = 1'b0; PWRITE = wr; PADDR = addr;
        PWDATA = data; PSTRB = strb; cfg_wait = wcfg; cfg_err_inject = inj;
        @(posedge PCLK); #1;
        PENABLE = 1'b1; cfg_wait = 4'd0; cfg_err_inject = 1'b0;
        n = 0;
        while (PREADY !== 1'b1 && n < 40) begin
            @(posedge PCLK); #1;
            n++;
        end
        chk("no_timeout", 32'(n < 40), 32'd1);
        waits  = n;
        rdata  = PRDATA;
        slverr = PSLVERR;
        @(posedge PCLK); #1;
        chk("ready_one_cycle", 32'(PREADY), 32'd0);
        PSEL = 32'h0; PENABLE = 1'b0;
    endtask

    initial begin
        PRESETn = 1'b0; PADDR = '0; PSEL = '0; PENABLE = 1'b0; PWRITE = 1'b0;
        PWDATA = '0; PSTRB = '0; cfg_wait = '0; cfg_err_inject = 1'b0;
        #12;
        chk("rst_pready", 32'(PREADY), 32'd0);
        chk("rst_pslverr", 32'(PSLVERR), 32'd0);
        chk("rst_prdata", PRDATA, 32'h0);
        chk("rst_prot_err", 32'(prot_err), 32'd0);
        chk("rst_count", 32'(xfer_count), 32'd0);
        PRESETn = 1'b1;
        @(posedge PCLK); #1;

        // Basic write / readback, zero wait states
        xfer(1'b1, 32'h1010, 32'hDEADBEEF, 4'hF, 4'd0, 1'b0, rd, se, wt);
        chk("w0_waits", 32'(wt), 32'd0);
        chk("w0_slverr", 32'(se), 32'd0);
        xfer(1'b0, 32'h1010, 32'h0, 4'h0, 4'd0, 1'b0, rd, se, wt);
        chk("r0_waits", 32'(wt), 32'd0);
        chk("r0_data", rd, 32'hDEADBEEF);
        chk("r0_slverr", 32'(se), 32'd0);
        chk("r0_count", 32'(xfer_count), 32'd2);

        // Byte-lane write
        xfer(1'b1, 32'h1020, 32'hFFFFFFFF, 4'hF, 4'd0, 1'b0, rd, se, wt);
        xfer(1'b1, 32'h1020, 32'h11223344, 4'h5, 4'd0, 1'b0, rd, se, wt);
        xfer(1'b0, 32'h1020, 32'h0, 4'hF, 4'd0, 1'b0, rd, se, wt);
        chk("strb_data", rd, 32'hFF22FF44);
        chk("strb_count", 32'(xfer_count), 32'd5);

        // Three wait states, cfg_wait cleared during the wait
        xfer(1'b0, 32'h1010, 32'h0, 4'h0, 4'd3, 1'b0, rd, se, wt);
        chk("wait3_waits", 32'(wt), 32'd3);
        chk("wait3_data", rd, 32'hDEADBEEF);
        chk("wait3_count", 32'(xfer_count), 32'd6);

        // Error responses
        xfer(1'b0, 32'h1400, 32'h0, 4'h0, 4'd0, 1'b0, rd, se, wt);
        chk("oow_slverr", 32'(se), 32'd1);
        chk("oow_data", rd, 32'h0);
        xfer(1'b0, 32'h1002, 32'h0, 4'h0, 4'd0, 1'b0, rd, se, wt);
        chk("mis_slverr", 32'(se), 32'd1);
        chk("mis_data", rd, 32'h0);
        xfer(1'b1, 32'h1010, 32'h12345678, 4'hF, 4'd1, 1'b1, rd, se, wt);
        chk("inj_slverr", 32'(se), 32'd1);
        chk("inj_waits", 32'(wt), 32'd1);
        xfer(1'b0, 32'h1010, 32'h0, 4'h0, 4'd0, 1'b0, rd, se, wt);
        chk("inj_mem_kept", rd, 32'hDEADBEEF);
        xfer(1'b0, 32'h0FFC, 32'h0, 4'h0, 4'd0, 1'b0, rd, se, wt);
        chk("below_slverr", 32'(se), 32'd1);
        chk("err_count", 32'(xfer_count), 32'd11);

        // Empty strobe write completes OKAY without touching memory
        xfer(1'b1, 32'h1010, 32'h00000000, 4'h0, 4'd0, 1'b0, rd, se, wt);
        chk("strb0_slverr", 32'(se), 32'd0);
        xfer(1'b0, 32'h1010, 32'h0, 4'h0, 4'd0, 1'b0, rd, se, wt);
        chk("strb0_data", rd, 32'hDEADBEEF);
        chk("strb0_count", 32'(xfer_count), 32'd13);

        // Abort: PSEL dropped in the second wait cycle of a write
        PSEL = 32'h1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 32'h1010;
        PWDATA = 32'hCAFEF00D; PSTRB = 4'hF; cfg_wait = 4'd3;
        @(posedge PCLK); #1;
        PENABLE = 1'b1;
        chk("abort_ready_a", 32'(PREADY), 32'd0);
        @(posedge PCLK); #1;
        chk("abort_ready_b", 32'(PREADY), 32'd0);
        PSEL = 32'h0;
        @(posedge PCLK); #1;
        chk("abort_prot_err", 32'(prot_err), 32'd1);
        chk("abort_ready_c", 32'(PREADY), 32'd0);
        PENABLE = 1'b0;
        @(posedge PCLK); #1;
        chk("abort_prot_pulse", 32'(prot_err), 32'd0);
        chk("abort_ready_d", 32'(PREADY), 32'd0);
        chk("abort_count", 32'(xfer_count), 32'd13);

        // Access phase without a setup phase
        PSEL = 32'h1; PENABLE = 1'b1;
        @(posedge PCLK); #1;
        chk("nosetup_prot_err", 32'(prot_err), 32'd1);
        PSEL = 32'h0; PENABLE = 1'b0;
        @(posedge PCLK); #1;
        chk("nosetup_pulse", 32'(prot_err), 32'd0);

        xfer(1'b0, 32'h1010, 32'h0, 4'h0, 4'd0, 1'b0, rd, se, wt);
        chk("post_abort_data", rd, 32'hDEADBEEF);
        chk("post_abort_slverr", 32'(se), 32'd0);
        chk("post_abort_count", 32'(xfer_count), 32'd14);

        // Reset asserted during a WAIT-state write
        PSEL = 32'h1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 32'h1010;
        PWDATA = 32'h55AA55AA; PSTRB = 4'hF; cfg_wait = 4'd5;
        @(posedge PCLK); #1;
        PENABLE = 1'b1;
        @(posedge PCLK); #2;
        PRESETn = 1'b0;
        #1;
        chk("rstw_pready", 32'(PREADY), 32'd0);
        chk("rstw_pslverr", 32'(PSLVERR), 32'd0);
        chk("rstw_count", 32'(xfer_count), 32'd0);
        PSEL = 32'h0; PENABLE = 1'b0;
        #2;
        PRESETn = 1'b1;
        @(posedge PCLK); #1;
        xfer(1'b0, 32'h1010, 32'h0, 4'h0, 4'd0, 1'b0, rd, se, wt);
        chk("rstw_mem_kept", rd, 32'hDEADBEEF);
        chk("rstw_count_restart", 32'(xfer_count), 32'd1);

        // Reset asserted while PREADY is high
        PSEL = 32'h1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 32'h1010;
        PWDATA = 32'h0BADF00D; PSTRB = 4'hF; cfg_wait = 4'd0;
        @(posedge PCLK); #1;
        PENABLE = 1'b1;
        chk("rstr_pready_high", 32'(PREADY), 32'd1);
        #2;
        PRESETn = 1'b0;
        #1;
        chk("rstr_pready", 32'(PREADY), 32'd0);
        chk("rstr_prdata", PRDATA, 32'h0);
        PSEL = 32'h0; PENABLE = 1'b0;
        #2;
        PRESETn = 1'b1;
        @(posedge PCLK); #1;
        xfer(1'b0, 32'h1010, 32'h0, 4'h0, 4'd0, 1'b0, rd, se, wt);
        chk("rstr_mem_kept", rd, 32'hDEADBEEF);
        xfer(1'b0, 32'h1020, 32'h0, 4'h0, 4'd0, 1'b0, rd, se, wt);
        chk("rstr_mem_kept2", rd, 32'hFF22FF44);
        chk("rstr_count", 32'(xfer_count), 32'd2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/apb4_slave_mem_responder.md
Name: apb4_slave_mem_responder

Overview:
- Synthesisable, parametrised APB4 completer standing in for a peripheral on the APB bus in block- and subsystem-level benches.
- Decodes its own PSEL bit and backs transfers with an internal word memory.
- Supports PSTRB byte-lane writes, programmable wait states, and PSLVERR generation from address decode or per-transfer error injection.
- Flags requester protocol violations and counts completed transfers.

Parameters:
- ADDR_WIDTH, 32, PADDR width.
- DATA_WIDTH, 32, PWDATA/PRDATA width; legal values 8, 16, 32, 64.
- NUM_SEL, 32, width of the shared PSEL vector.
- SEL_INDEX, 0, PSEL bit decoded by this instance; must be less than NUM_SEL.
- DEPTH, 256, number of DATA_WIDTH words in the memory.
- BASE_ADDR, 0, byte address of word 0; must be aligned to DATA_WIDTH/8.

Ports:
- PCLK  input  1  bus clock; all state updates on the rising edge.
- PRESETn  input  1  asynchronous active-low reset.
- PADDR  input  ADDR_WIDTH  byte address.
- PSEL  input  NUM_SEL  select vector; only bit SEL_INDEX is used.
- PENABLE  input  1  access-phase indicator.
- PWRITE  input  1  1 = write, 0 = read.
- PWDATA  input  DATA_WIDTH  write data.
- PSTRB  input  DATA_WIDTH/8  write byte-lane enables.
- PRDATA  output  DATA_WIDTH  read data.
- PREADY  output  1  transfer completes when high in an access cycle.
- PSLVERR  output  1  error response; valid only while PREADY=1.
- cfg_wait  input  4  wait states to insert; sampled at setup.
- cfg_err_inject  input  1  force PSLVERR on the transfer being set up; sampled at setup.
- prot_err  output  1  one-cycle pulse on a requester protocol violation.
- xfer_count  output  16  completed transfers (OK and error); wraps at 0xFFFF to 0.

Behaviour:
- Reset (async assert, sync release): state=IDLE, PREADY=0, PSLVERR=0, PRDATA=0, prot_err=0, xfer_count=0, wait counter=0. Memory contents are not cleared.
- FSM states are IDLE, WAIT and READY.
- IDLE: at a rising edge with PSEL[SEL_INDEX]=1 and PENABLE=0 (setup), the block:
  - latches PADDR, PWRITE, PWDATA and PSTRB;
  - computes err = cfg_err_inject OR address out of window OR misaligned;
  - if cfg_wait=0: goes to READY and registers PREADY<=1, PSLVERR<=err, PRDATA<=(read and !err) ? mem[idx] : 0;
  - if cfg_wait>0: goes to WAIT with cnt<=cfg_wait.
- IDLE with PSEL=1 and PENABLE=1 (access without setup): prot_err pulses, block stays in IDLE.
- WAIT: each edge decrements cnt. At the edge where cnt=1, the block goes to READY and registers PREADY, PSLVERR and PRDATA as above. Result: exactly cfg_wait access cycles with PREADY=0.
- READY: at an edge with PSEL=1 and PENABLE=1, the transfer completes:
  - a write with !err updates the bytes enabled in PSTRB;
  - xfer_count increments;
  - PREADY<=0, PSLVERR<=0, PRDATA<=0, then IDLE.
- Completion latency = 2 + cfg_wait cycles from setup start. Back-to-back setups directly after completion are accepted with no bubble.
- Address decode:
  - off = PADDR - BASE_ADDR; idx = off >> log2(DATA_WIDTH/8).
  - Misaligned when the low log2(DATA_WIDTH/8) bits of PADDR are nonzero.
  - Out of window when PADDR < BASE_ADDR or idx >= DEPTH.
- Error transfers never modify memory, and PRDATA=0 on them.
- A write with PSTRB=0 completes OKAY and leaves memory unchanged.
- PSTRB is ignored on reads.
- Abort: if PSEL[SEL_INDEX] drops, or PENABLE=0, during WAIT or READY, the block:
  - pulses prot_err;
  - returns to IDLE with outputs at reset values;
  - performs no write and no count.
- A mid-transfer change of PADDR/PWRITE/PWDATA is ignored because the values latched at setup are used.
- Reset mid-transfer: outputs clear immediately and asynchronously, the in-flight write is discarded, and memory is otherwise preserved.
- cfg_wait and cfg_err_inject changes mid-transfer have no effect until the next setup.

Test Plan:
- Write 0xDEADBEEF to BASE_ADDR+0x10, PSTRB=0xF, cfg_wait=0, then read it back -> each transfer completes 2 cycles after setup, PREADY high for 1 cycle, PRDATA=0xDEADBEEF, PSLVERR=0, xfer_count=2.
- Write 0x11223344 with PSTRB=0x5 over word 0xFFFFFFFF, then read -> PRDATA=0xFF22FF44.
- cfg_wait=3 read -> exactly 3 access cycles with PREADY=0, completion on cycle 5; change cfg_wait to 0 during the wait -> still 3 wait states.
- Reads at BASE_ADDR+DEPTH*4 and BASE_ADDR+0x2, and a write with cfg_err_inject=1 -> PSLVERR=1, PRDATA=0, memory unchanged, xfer_count increments each time.
- Drop PSEL in the 2nd wait cycle of a write -> prot_err pulses once, PREADY never asserted, memory unchanged, next setup completes normally.
- Assert PRESETn=0 during a WAIT-state write -> PREADY, PSLVERR and xfer_count clear without waiting for a clock edge; previously written data reads back intact after reset.
